// File: rtl/ahb2apb_sync_mux_if.sv
// Bus bundle for ahb2apb_sync_mux: AHB-Lite slave side plus the APB master
// side with NUM_SLV select/ready/error lanes. The bridge connects through the
// slave modport; the bus/peripheral side connects through the master modport.
interface ahb2apb_sync_mux_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLV    = 4
);
    logic                          ahb_hsel;
    logic [1:0]                    ahb_htrans;
    logic [ADDR_WIDTH-1:0]         ahb_haddr;
    logic                          ahb_hwrite;
    logic [DATA_WIDTH-1:0]         ahb_hwdata;
    logic                          ahb_hready;
    logic                          ahb_hreadyout;
    logic                          ahb_hresp;
    logic [DATA_WIDTH-1:0]         ahb_hrdata;
    logic [NUM_SLV-1:0]            apb_psel;
    logic                          apb_penable;
    logic                          apb_pwrite;
    logic [ADDR_WIDTH-1:0]         apb_paddr;
    logic [DATA_WIDTH-1:0]         apb_pwdata;
    logic [NUM_SLV-1:0]            apb_pready;
    logic [NUM_SLV*DATA_WIDTH-1:0] apb_prdata;
    logic [NUM_SLV-1:0]            apb_pslverr;

    modport slave (
        input  ahb_hsel, ahb_htrans, ahb_haddr, ahb_hwrite, ahb_hwdata, ahb_hready,
        output ahb_hreadyout, ahb_hresp, ahb_hrdata,
        output apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
        input  apb_pready, apb_prdata, apb_pslverr
    );

    modport master (
        output ahb_hsel, ahb_htrans, ahb_haddr, ahb_hwrite, ahb_hwdata, ahb_hready,
        input  ahb_hreadyout, ahb_hresp, ahb_hrdata,
        input  apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
        output apb_pready, apb_prdata, apb_pslverr
    );
endinterface

// File: rtl/ahb2apb_sync_mux.sv
// Single-clock AHB-Lite to APB bridge with built-in slave decoder.
// One AHB transfer at a time becomes CAPT -> SETUP -> ACCESS on the slave
// selected by haddr[SEL_LSB +: SEL_WIDTH]; APB wait states stretch the AHB
// data phase and a PREADY timeout bounds ACCESS to TIMEOUT cycles.
// Optional feature macro: AHB2APB_ERR_EN -- when defined, pslverr, decode
// errors and timeouts produce the two-cycle AHB ERROR response; otherwise
// they complete as OKAY (failed reads return zero).
module ahb2apb_sync_mux #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLV    = 4,
    parameter int SEL_LSB    = 12,
    parameter int SEL_WIDTH  = 2,
    parameter int TIMEOUT    = 256
) (
    input logic              ahb_hclk,
    input logic              ahb_hrstn,
    ahb2apb_sync_mux_if.slave bus
);

`ifdef AHB2APB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {IDLE, CAPT, SETUP, ACCESS, ERR1, ERR2} state_t;

    state_t                  state, next_state;
    logic [SEL_WIDTH-1:0]    idx;
    logic [CNT_W-1:0]        cnt;
    logic                    accept, idx_ok, timeout;
    logic                    pready_sel, pslverr_sel;
    logic [DATA_WIDTH-1:0]   prdata_sel;
    logic [NUM_SLV-1:0]      sel_onehot;
    logic                    rd_load, rd_zero;

    logic                    hreadyout_q, hresp_q;
    logic [DATA_WIDTH-1:0]   hrdata_q, pwdata_q;
    logic [NUM_SLV-1:0]      psel_q;
    logic                    penable_q, pwrite_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;

    logic unused_htrans0;
    assign unused_htrans0 = bus.ahb_htrans[0];

    assign accept  = bus.ahb_hsel & bus.ahb_htrans[1] & bus.ahb_hready &
                     ((state == IDLE) | (state == ERR2));
    assign idx_ok  = (int'(idx) < NUM_SLV);
    assign timeout = (TIMEOUT != 0) && (cnt == CNT_LAST) && !pready_sel;

    // Route the addressed slave's response lanes and build its select vector
    always_comb begin
        sel_onehot  = '0;
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        prdata_sel  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (int'(idx) == i) begin
                sel_onehot[i] = 1'b1;
                pready_sel    = bus.apb_pready[i];
                pslverr_sel   = bus.apb_pslverr[i];
                prdata_sel    = bus.apb_prdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // FSM state register
    always_ff @(posedge ahb_hclk or negedge ahb_hrstn) begin
        if (!ahb_hrstn) state <= IDLE;
        else            state <= next_state;
    end

    // Next-state decode plus hrdata update requests for the completing cycle
    always_comb begin
        next_state = state;
        rd_load    = 1'b0;
        rd_zero    = 1'b0;
        case (state)
            IDLE:   if (accept) next_state = CAPT;
            CAPT: begin
                if (idx_ok) begin
                    next_state = SETUP;
                end else begin
                    next_state = ERR_EN ? ERR1 : IDLE;
                    rd_zero    = !ERR_EN && !pwrite_q;
                end
            end
            SETUP:  next_state = ACCESS;
            ACCESS: begin
                if (pready_sel && !pslverr_sel) begin
                    next_state = IDLE;
                    rd_load    = !pwrite_q;
                end else if (pready_sel || timeout) begin
                    next_state = ERR_EN ? ERR1 : IDLE;
                    rd_zero    = !ERR_EN && !pwrite_q;
                end
            end
            ERR1:   next_state = ERR2;
            ERR2:   next_state = accept ? CAPT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // ACCESS-cycle counter; held at zero outside ACCESS so entry starts at 0
    always_ff @(posedge ahb_hclk or negedge ahb_hrstn) begin
        if (!ahb_hrstn)            cnt <= '0;
        else if (state != ACCESS)  cnt <= '0;
        else if (!pready_sel)      cnt <= cnt + 1'b1;
    end

    // Registered AHB/APB outputs derived from the state being entered
    always_ff @(posedge ahb_hclk or negedge ahb_hrstn) begin
        if (!ahb_hrstn) begin
            idx         <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            hreadyout_q <= 1'b1;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            hrdata_q    <= '0;
        end else begin
            if (accept) begin
                paddr_q  <= bus.ahb_haddr;
                pwrite_q <= bus.ahb_hwrite;
                idx      <= bus.ahb_haddr[SEL_LSB +: SEL_WIDTH];
            end
            if (state == CAPT) pwdata_q <= bus.ahb_hwdata;
            hreadyout_q <= (next_state == IDLE) || (next_state == ERR2);
            psel_q      <= ((next_state == SETUP) || (next_state == ACCESS)) ? sel_onehot : '0;
            penable_q   <= (next_state == ACCESS);
            if (rd_load)      hrdata_q <= prdata_sel;
            else if (rd_zero) hrdata_q <= '0;
        end
    end

`ifdef AHB2APB_ERR_EN
    // ERROR response is driven through both ERR1 and ERR2
    always_ff @(posedge ahb_hclk or negedge ahb_hrstn) begin
        if (!ahb_hrstn) hresp_q <= 1'b0;
        else            hresp_q <= (next_state == ERR1) || (next_state == ERR2);
    end
`else
    assign hresp_q = 1'b0;
`endif

    assign bus.ahb_hreadyout = hreadyout_q;
    assign bus.ahb_hresp     = hresp_q;
    assign bus.ahb_hrdata    = hrdata_q;
    assign bus.apb_psel      = psel_q;
    assign bus.apb_penable   = penable_q;
    assign bus.apb_pwrite    = pwrite_q;
    assign bus.apb_paddr     = paddr_q;
    assign bus.apb_pwdata    = pwdata_q;

endmodule
